// File: rtl/clm_serial_mult_ctrl_pkg.sv
// Shared types for the serial CLM multiplier: redundancy width, element type, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clm_serial_mult_ctrl_pkg;

  // Number of redundancy bits appended to the 8-bit field element.
  localparam int CLM_D = 0;
  localparam int CLM_W = 8 + CLM_D;

  // Lifted field element at the default redundancy.
  typedef logic [CLM_W-1:0] state_t;

  // Controller phases: waiting for operands, scanning p1, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } clm_mul_fsm_t;

endpackage

// File: rtl/clm_serial_mult_ctrl_modular_shift.sv
// Multiply a lifted element by x modulo PQ (the top bit of PQ is implicit).
// Latency: combinational.
// Backpressure: none.
module clm_serial_mult_ctrl_modular_shift #(
  parameter int W = 8
) (
  output logic [W-1:0] out,
  input  logic [W-1:0] in,
  input  logic [W-1:0] poly
);

  // Shift left one place and fold the bit leaving the top back in via PQ.
  assign out = {in[W-2:0], 1'b0} ^ ({W{in[W-1]}} & poly);

endmodule

// File: rtl/clm_serial_mult_ctrl.sv
// Bit-serial CLM product p1*p2 mod PQ, one p1 bit per cycle (LSB first).
// Latency: W cycles from operand accept to out_valid; W+2 cycles minimum per product.
// Backpressure: result held in DONE until out_ready; operands accepted only in IDLE.
module clm_serial_mult_ctrl
  import clm_serial_mult_ctrl_pkg::*;
#(
  parameter  int d     = CLM_D,
  localparam int W     = 8 + d,
  localparam int CNT_W = $clog2(8 + d)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] p1,
  input  logic [W-1:0] p2,
  input  logic [W-1:0] pq,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  clm_mul_fsm_t     r_state;
  clm_mul_fsm_t     w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_pq;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_out;
  logic [CNT_W-1:0] r_cnt;

  logic [W-1:0]     w_b_shift;
  logic [W-1:0]     w_acc_nxt;
  logic             w_last;
  logic             w_accept;

  clm_serial_mult_ctrl_modular_shift #(
    .W (W)
  ) u_modular_shift (
    .out  (w_b_shift),
    .in   (r_b),
    .poly (r_pq)
  );

  // Partial product for the current p1 bit folded into the running sum.
  assign w_acc_nxt = r_acc ^ ({W{r_a[r_cnt]}} & r_b);
  assign w_last    = (r_cnt == LAST_BIT);
  assign out       = r_out;

  // Phase register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next phase and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, serial accumulate, and result publish on the final bit.
  // The result register is separate so partial sums never reach out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_pq  <= '0;
      r_acc <= '0;
      r_out <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= p1;
      r_b   <= p2;
      r_pq  <= pq;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nxt;
      r_b   <= w_b_shift;
      if (w_last) begin
        r_cnt <= '0;
        r_out <= w_acc_nxt;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clm_serial_mult_ctrl.sv
// Bench for the serial CLM multiplier: d=0 directed vectors plus d=2 random products.
// Latency: n/a.
// Backpressure: exercised via held out_ready.
module tb_clm_serial_mult_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv   [2];
  logic       ordy [2];
  logic [9:0] a    [2];
  logic [9:0] b    [2];
  logic [9:0] q    [2];

  logic       ov0, ir0, bz0, ov2, ir2, bz2;
  logic [7:0] o0;
  logic [9:0] o2;

  wire        ov [2];
  wire        ir [2];
  wire        bz [2];
  wire  [9:0] o  [2];
  assign ov[0] = ov0;
  assign ov[1] = ov2;
  assign ir[0] = ir0;
  assign ir[1] = ir2;
  assign bz[0] = bz0;
  assign bz[1] = bz2;
  assign o[0]  = {2'b00, o0};
  assign o[1]  = o2;

  clm_serial_mult_ctrl #(.d(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[0]),
    .in_ready  (ir0),
    .p1        (a[0][7:0]),
    .p2        (b[0][7:0]),
    .pq        (q[0][7:0]),
    .out_valid (ov0),
    .out_ready (ordy[0]),
    .out       (o0),
    .busy      (bz0)
  );

  clm_serial_mult_ctrl #(.d(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[1]),
    .in_ready  (ir2),
    .p1        (a[1]),
    .p2        (b[1]),
    .pq        (q[1]),
    .out_valid (ov2),
    .out_ready (ordy[1]),
    .out       (o2),
    .busy      (bz2)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full carry-less product, then long division by x^w + pq.
  function automatic logic [9:0] ref_mul(input logic [9:0] x, input logic [9:0] y,
                                         input logic [9:0] pq, input int w);
    logic [19:0] prod;
    logic [19:0] poly;
    prod = '0;
    poly = (20'h1 << w) | 20'(pq);
    for (int i = 0; i < w; i++)
      if (x[i]) prod ^= (20'(y) << i);
    for (int j = 2 * w - 2; j >= w; j--)
      if (prod[j]) prod ^= (poly << (j - w));
    return prod[9:0];
  endfunction

  // Transaction-level model: idle / computing for W cycles / holding result.
  int         m_mode [2];
  int         m_left [2];
  logic [9:0] m_res  [2];
  logic [9:0] m_out  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_mode[k] = 0;
        m_out[k]  = '0;
      end else begin
        case (m_mode[k])
          0: if (iv[k]) begin
               m_res[k]  = ref_mul(a[k], b[k], q[k], k ? 10 : 8);
               m_left[k] = k ? 10 : 8;
               m_mode[k] = 1;
             end
          1: begin
               m_left[k] = m_left[k] - 1;
               if (m_left[k] == 0) begin
                 m_mode[k] = 2;
                 m_out[k]  = m_res[k];
               end
             end
          default: if (ordy[k]) m_mode[k] = 0;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_out_valid%0d", k), 32'(ov[k]), 32'(m_mode[k] == 2));
        chk($sformatf("cyc_in_ready%0d", k), 32'(ir[k]), 32'(m_mode[k] == 0));
        chk($sformatf("cyc_busy%0d", k), 32'(bz[k]), 32'(m_mode[k] != 0));
        chk($sformatf("cyc_out%0d", k), 32'(o[k]), 32'(m_out[k]));
      end
    end
  end

  // One transaction on DUT k; lit is the hand-computed result when has_lit.
  task automatic run(input int k, input logic [9:0] x, input logic [9:0] y, input logic [9:0] pq,
                     input bit has_lit, input logic [9:0] lit, input int hold, input bit disturb);
    int lat;
    int w;
    logic [9:0] exp;
    w   = k ? 10 : 8;
    exp = has_lit ? lit : ref_mul(x, y, pq, w);
    ordy[k] = (hold == 0);
    a[k] = x;
    b[k] = y;
    q[k] = pq;
    iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 40) begin
      if (disturb && lat == 3) begin
        a[k] = ~x;
        b[k] = y ^ 10'h155;
        q[k] = pq ^ 10'h0AA;
        iv[k] = 1'b1;
      end
      if (disturb && lat == 5) iv[k] = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency%0d", k), 32'(lat), 32'(w));
    chk($sformatf("result%0d", k), 32'(o[k]), 32'(exp));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_out_valid", 32'(ov[k]), 32'd1);
        chk("hold_out", 32'(o[k]), 32'(exp));
        chk("hold_in_ready", 32'(ir[k]), 32'd0);
      end
      ordy[k] = 1'b1;
    end
    @(negedge clk);
    chk("drop_out_valid", 32'(ov[k]), 32'd0);
    chk("back_in_ready", 32'(ir[k]), 32'd1);
    chk("kept_out", 32'(o[k]), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b0;
      a[k] = '0;
      b[k] = '0;
      q[k] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_out", 32'(o0), 32'h0);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_in_ready", 32'(ir0), 32'd1);
    chk("rst_busy", 32'(bz0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed d=0 vectors over AES polynomial.
    run(0, 10'h57, 10'h83, 10'h1B, 1'b1, 10'hC1, 0, 1'b0);
    run(0, 10'h57, 10'h13, 10'h1B, 1'b1, 10'hFE, 0, 1'b0);
    run(0, 10'h00, 10'hFF, 10'h1B, 1'b1, 10'h00, 0, 1'b0);
    run(0, 10'h01, 10'hA5, 10'h1B, 1'b1, 10'hA5, 0, 1'b0);

    // Backpressure: result held for 20 cycles.
    run(0, 10'h57, 10'h83, 10'h1B, 1'b1, 10'hC1, 20, 1'b0);

    // Operand and in_valid disturbance during RUN; no second transaction follows.
    run(0, 10'h57, 10'h83, 10'h1B, 1'b1, 10'hC1, 0, 1'b1);
    repeat (12) begin
      @(negedge clk);
      chk("no_second_txn", 32'(ov0), 32'd0);
    end
    chk("idle_after_disturb", 32'(bz0), 32'd0);

    // Reset after four bits processed.
    ordy[0] = 1'b1;
    a[0] = 10'h57;
    b[0] = 10'h83;
    q[0] = 10'h1B;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out", 32'(o0), 32'h0);
    chk("midrst_out_valid", 32'(ov0), 32'd0);
    chk("midrst_in_ready", 32'(ir0), 32'd1);
    chk("midrst_busy", 32'(bz0), 32'd0);
    @(negedge clk);
    run(0, 10'h57, 10'h83, 10'h1B, 1'b1, 10'hC1, 0, 1'b0);

    // Randomized d=2 products against the reference.
    for (int n = 0; n < 1000; n++) begin
      run(1, 10'($urandom), 10'($urandom), 10'($urandom), 1'b0, 10'h0, 0, 1'b0);
    end

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
